i2c_slave_ctrl: RTL and testbench

// - I2C slave protocol controller that sequences the 128x8 I2C register RAM.
// - Oversamples SCL/SDA on the system clock and decodes START, STOP, the device address and a word address.
// - Issues single-cycle RAM write/read strobes with an auto-incrementing address pointer.
// - Drives SDA open-drain, as pull-low enable only.

---
 rtl/i2c_ctrl_pkg.sv | 21 ++
 rtl/i2c_bus_sync.sv | 79 +++++++
 rtl/i2c_slave_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_i2c_slave_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_ctrl_pkg.sv
// Shared types and constants for the I2C slave controller.
package i2c_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE,
        DEV_ADDR,
        DEV_ACK,
        WORD_ADDR,
        WORD_ACK,
        WR_DATA,
        WR_ACK,
        RD_LOAD,
        RD_DATA,
        RD_ACK
    } i2c_state_t;

    localparam logic I2C_ACK           = 1'b0;
    localparam logic I2C_NACK          = 1'b1;
    localparam int   I2C_BITS_PER_BYTE = 8;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronisers with SCL edge and START/STOP strobes.
// Optional 3-sample majority filter when I2C_GLITCH_FILTER_EN is defined.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock_in,
    input  logic reset_in,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda_level,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync_p0;
    logic [SYNC_STAGES-1:0] sda_sync_p0;
    logic                   scl_f_p1;
    logic                   sda_f_p1;
    logic                   scl_d_p2;
    logic                   sda_d_p2;

    // Idle bus reads high, so the chains reset to 1 to avoid false edges.
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            scl_sync_p0 <= '1;
            sda_sync_p0 <= '1;
        end else begin
            scl_sync_p0 <= {scl_sync_p0[SYNC_STAGES-2:0], scl_in};
            sda_sync_p0 <= {sda_sync_p0[SYNC_STAGES-2:0], sda_in};
        end
    end

`ifdef I2C_GLITCH_FILTER_EN
    logic [2:0] scl_hist;
    logic [2:0] sda_hist;

    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

    // Filter stage: one history flop plus one registered vote.
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            scl_hist <= '1;
            sda_hist <= '1;
            scl_f_p1 <= 1'b1;
            sda_f_p1 <= 1'b1;
        end else begin
            scl_hist <= {scl_hist[1:0], scl_sync_p0[SYNC_STAGES-1]};
            sda_hist <= {sda_hist[1:0], sda_sync_p0[SYNC_STAGES-1]};
            scl_f_p1 <= maj3(scl_hist);
            sda_f_p1 <= maj3(sda_hist);
        end
    end
`else
    assign scl_f_p1 = scl_sync_p0[SYNC_STAGES-1];
    assign sda_f_p1 = sda_sync_p0[SYNC_STAGES-1];
`endif

    // Edge-detect stage.
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            scl_d_p2 <= 1'b1;
            sda_d_p2 <= 1'b1;
        end else begin
            scl_d_p2 <= scl_f_p1;
            sda_d_p2 <= sda_f_p1;
        end
    end

    assign sda_level = sda_f_p1;
    assign scl_rise  =  scl_f_p1 & ~scl_d_p2;
    assign scl_fall  = ~scl_f_p1 &  scl_d_p2;
    assign start_det =  scl_f_p1 &  scl_d_p2 &  sda_d_p2 & ~sda_f_p1;
    assign stop_det  =  scl_f_p1 &  scl_d_p2 & ~sda_d_p2 &  sda_f_p1;

endmodule

// File: rtl/i2c_slave_ctrl.sv
// I2C slave controller sequencing a 128x8 register RAM with an auto-incrementing pointer.
// Build option I2C_GLITCH_FILTER_EN enables the input majority filter in i2c_bus_sync.
module i2c_slave_ctrl
    import i2c_ctrl_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         ADDR_W      = 7,
    parameter int         DATA_W      = 8,
    parameter int         SYNC_STAGES = 2
) (
    input  logic              clock_in,
    input  logic              reset_in,
    input  logic              scl_in,
    input  logic              sda_in,
    output logic              sda_oe_out,
    output logic              ram_wr_en_out,
    output logic              ram_rd_en_out,
    output logic [ADDR_W-1:0] ram_addr_out,
    output logic [DATA_W-1:0] ram_wdata_out,
    input  logic [DATA_W-1:0] ram_rdata_in,
    output logic              busy_out
);

    localparam logic [3:0] BYTE_LAST = 4'(I2C_BITS_PER_BYTE - 1);
    localparam logic [3:0] BYTE_END  = 4'(I2C_BITS_PER_BYTE);

    logic              sda_level;
    logic              scl_rise;
    logic              scl_fall;
    logic              start_det;
    logic              stop_det;

    i2c_state_t        state;
    logic [3:0]        bit_cnt;
    logic [DATA_W-2:0] rx_shift;
    logic [DATA_W-1:0] rx_byte;
    logic [DATA_W-1:0] tx_shift;
    logic [ADDR_W-1:0] pointer;
    logic              rw;
    logic              ack_drv;
    logic [1:0]        ld_phase;
    logic              shifting;
    logic              byte_done;

    i2c_bus_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_bus_sync (
        .clock_in  (clock_in),
        .reset_in  (reset_in),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .sda_level (sda_level),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    assign rx_byte      = {rx_shift, sda_level};
    assign shifting     = (state == DEV_ADDR) || (state == WORD_ADDR) || (state == WR_DATA);
    assign byte_done    = scl_rise && (bit_cnt == BYTE_LAST);
    assign ram_addr_out = pointer;

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            pointer       <= '0;
            rw            <= 1'b0;
            ack_drv       <= 1'b0;
            ld_phase      <= '0;
            sda_oe_out    <= 1'b0;
            ram_wr_en_out <= 1'b0;
            ram_rd_en_out <= 1'b0;
            ram_wdata_out <= '0;
            busy_out      <= 1'b0;
        end else begin
            ram_wr_en_out <= 1'b0;
            ram_rd_en_out <= 1'b0;
            if (stop_det) begin
                state      <= IDLE;
                busy_out   <= 1'b0;
                sda_oe_out <= 1'b0;
                ack_drv    <= 1'b0;
            end else if (start_det) begin
                state      <= DEV_ADDR;
                bit_cnt    <= '0;
                sda_oe_out <= 1'b0;
                ack_drv    <= 1'b0;
            end else begin
                if (scl_rise && shifting) begin
                    rx_shift <= rx_byte[DATA_W-2:0];
                    bit_cnt  <= bit_cnt + 1'b1;
                end
                case (state)
                    IDLE: ;
                    DEV_ADDR: if (byte_done) begin
                        bit_cnt <= '0;
                        if (rx_byte[DATA_W-1:1] == SLAVE_ADDR) begin
                            state    <= DEV_ACK;
                            busy_out <= 1'b1;
                            rw       <= rx_byte[0];
                        end else begin
                            state    <= IDLE;
                            busy_out <= 1'b0;
                        end
                    end
                    // ACK states: first fall drives ACK, the ACK-bit fall releases it.
                    DEV_ACK: begin
                        if (scl_fall) begin
                            if (!ack_drv) begin
                                sda_oe_out <= ~I2C_ACK;
                                ack_drv    <= 1'b1;
                            end else begin
                                sda_oe_out <= 1'b0;
                                ack_drv    <= 1'b0;
                                state      <= WORD_ADDR;
                            end
                        end else if (scl_rise && ack_drv && rw) begin
                            ack_drv  <= 1'b0;
                            ld_phase <= '0;
                            state    <= RD_LOAD;
                        end
                    end
                    WORD_ADDR: if (byte_done) begin
                        pointer <= rx_byte[ADDR_W-1:0];
                        bit_cnt <= '0;
                        state   <= WORD_ACK;
                    end
                    WORD_ACK: if (scl_fall) begin
                        if (!ack_drv) begin
                            sda_oe_out <= ~I2C_ACK;
                            ack_drv    <= 1'b1;
                        end else begin
                            sda_oe_out <= 1'b0;
                            ack_drv    <= 1'b0;
                            state      <= WR_DATA;
                        end
                    end
                    WR_DATA: if (byte_done) begin
                        ram_wdata_out <= rx_byte;
                        ram_wr_en_out <= 1'b1;
                        bit_cnt       <= '0;
                        state         <= WR_ACK;
                    end
                    WR_ACK: if (scl_fall) begin
                        if (!ack_drv) begin
                            sda_oe_out <= ~I2C_ACK;
                            ack_drv    <= 1'b1;
                        end else begin
                            sda_oe_out <= 1'b0;
                            ack_drv    <= 1'b0;
                            pointer    <= pointer + 1'b1;
                            state      <= WR_DATA;
                        end
                    end
                    // Fetch finishes during SCL high; first bit goes out on the next fall.
                    RD_LOAD: begin
                        case (ld_phase)
                            2'd0: begin
                                ram_rd_en_out <= 1'b1;
                                ld_phase      <= 2'd1;
                            end
                            2'd1: ld_phase <= 2'd2;
                            2'd2: begin
                                tx_shift <= ram_rdata_in;
                                ld_phase <= 2'd3;
                            end
                            default: if (scl_fall) begin
                                sda_oe_out <= ~tx_shift[DATA_W-1];
                                tx_shift   <= {tx_shift[DATA_W-2:0], 1'b0};
                                bit_cnt    <= '0;
                                state      <= RD_DATA;
                            end
                        endcase
                    end
                    RD_DATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end else if (scl_fall) begin
                            if (bit_cnt == BYTE_END) begin
                                sda_oe_out <= 1'b0;
                                bit_cnt    <= '0;
                                state      <= RD_ACK;
                            end else begin
                                sda_oe_out <= ~tx_shift[DATA_W-1];
                                tx_shift   <= {tx_shift[DATA_W-2:0], 1'b0};
                            end
                        end
                    end
                    RD_ACK: if (scl_rise) begin
                        if (sda_level == I2C_NACK) begin
                            state    <= IDLE;
                            busy_out <= 1'b0;
                        end else begin
                            pointer  <= pointer + 1'b1;
                            ld_phase <= '0;
                            state    <= RD_LOAD;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Directed plus randomized bench for i2c_slave_ctrl with a bus-level master and a memory model.
module tb_i2c_slave_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl_m;
    logic       sda_m;
    logic       sda_bus;
    logic       sda_oe;
    logic       ram_wr_en;
    logic       ram_rd_en;
    logic [6:0] ram_addr;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;
    logic       busy;

    always #5 clk = ~clk;

    assign sda_bus = sda_m & ~sda_oe;

    i2c_slave_ctrl dut (
        .clock_in      (clk),
        .reset_in      (rst),
        .scl_in        (scl_m),
        .sda_in        (sda_bus),
        .sda_oe_out    (sda_oe),
        .ram_wr_en_out (ram_wr_en),
        .ram_rd_en_out (ram_rd_en),
        .ram_addr_out  (ram_addr),
        .ram_wdata_out (ram_wdata),
        .ram_rdata_in  (ram_rdata),
        .busy_out      (busy)
    );

    // Bench RAM and strobe logger
    logic [7:0] mem [128];
    logic [6:0] wr_log_addr [256];
    logic [7:0] wr_log_data [256];
    logic [6:0] rd_log_addr [256];
    int wr_cnt = 0;
    int rd_cnt = 0;
    int overlap_cnt = 0;
    int oe_cnt = 0;
    int busy_cnt = 0;

    always @(posedge clk) begin
        if (ram_wr_en) begin
            mem[ram_addr] <= ram_wdata;
            if (wr_cnt < 256) begin
                wr_log_addr[wr_cnt] <= ram_addr;
                wr_log_data[wr_cnt] <= ram_wdata;
            end
            wr_cnt <= wr_cnt + 1;
        end
        if (ram_rd_en) begin
            ram_rdata <= mem[ram_addr];
            if (rd_cnt < 256) rd_log_addr[rd_cnt] <= ram_addr;
            rd_cnt <= rd_cnt + 1;
        end
        if (ram_wr_en && ram_rd_en) overlap_cnt <= overlap_cnt + 1;
        if (sda_oe) oe_cnt <= oe_cnt + 1;
        if (busy) busy_cnt <= busy_cnt + 1;
    end

    // Reference model: register contents and pointer, by protocol rules
    logic [7:0] ref_mem [128];
    int         ref_ptr = 0;
    logic [7:0] dbuf [8];
    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_clks(4);
        scl_m = 1'b1; wait_clks(8);
        sda_m = 1'b0; wait_clks(8);
        scl_m = 1'b0; wait_clks(4);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_clks(4);
        scl_m = 1'b1; wait_clks(8);
        sda_m = 1'b1; wait_clks(8);
    endtask

    // One bit: SDA set in the low phase, line sampled mid-high.
    task automatic bit_cycle(input logic b, output logic seen);
        sda_m = b; wait_clks(4);
        scl_m = 1'b1; wait_clks(4);
        seen = sda_bus; wait_clks(4);
        scl_m = 1'b0; wait_clks(4);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit glitch, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            if (glitch && i == 3) begin
                scl_m = 1'b1; wait_clks(1);
                scl_m = 1'b0; wait_clks(1);
            end
            bit_cycle(b[i], s);
        end
        bit_cycle(1'b1, ack);
    endtask

    task automatic recv_byte(output logic [7:0] b, input logic nack);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_cycle(1'b1, s);
            b[i] = s;
        end
        bit_cycle(nack, s);
    endtask

    task automatic write_txn(input logic [6:0] w, input int n, input int glitch_byte);
        logic ack;
        int   base;
        int   exp_a [8];
        base = wr_cnt;
        i2c_start();
        send_byte(8'hA0, 1'b0, ack);
        check("wr_dev_ack", ack, 0);
        check("wr_busy_set", busy, 1);
        send_byte({1'b0, w}, 1'b0, ack);
        check("wr_word_ack", ack, 0);
        ref_ptr = w;
        for (int i = 0; i < n; i++) begin
            send_byte(dbuf[i], i == glitch_byte, ack);
            check("wr_data_ack", ack, 0);
            exp_a[i] = ref_ptr;
            ref_mem[ref_ptr] = dbuf[i];
            ref_ptr = (ref_ptr + 1) % 128;
        end
        i2c_stop();
        wait_clks(4);
        check("wr_count", wr_cnt - base, n);
        for (int i = 0; i < n; i++) begin
            check("wr_addr", wr_log_addr[base + i], exp_a[i]);
            check("wr_data", wr_log_data[base + i], dbuf[i]);
        end
        check("wr_stop_busy", busy, 0);
    endtask

    task automatic read_txn(input logic [6:0] w, input bit set_word, input int n);
        logic       ack;
        logic [7:0] b;
        int         base;
        base = rd_cnt;
        i2c_start();
        if (set_word) begin
            send_byte(8'hA0, 1'b0, ack);
            check("rd_wdev_ack", ack, 0);
            send_byte({1'b0, w}, 1'b0, ack);
            check("rd_word_ack", ack, 0);
            ref_ptr = w;
            i2c_start();
        end
        send_byte(8'hA1, 1'b0, ack);
        check("rd_dev_ack", ack, 0);
        for (int i = 0; i < n; i++) begin
            recv_byte(b, i == n - 1);
            check("rd_data", b, ref_mem[ref_ptr]);
            check("rd_addr", rd_log_addr[base + i], ref_ptr);
            if (i < n - 1) ref_ptr = (ref_ptr + 1) % 128;
        end
        wait_clks(4);
        check("rd_nack_busy", busy, 0);
        i2c_stop();
        wait_clks(4);
        check("rd_count", rd_cnt - base, n);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       ack;
        logic       s;
        int         oe0, busy0, wr0, rd0;
        logic [6:0] w;
        int         n;

        rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
        wait_clks(5);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_wr_en", ram_wr_en, 0);
        check("rst_rd_en", ram_rd_en, 0);
        check("rst_addr", ram_addr, 0);
        check("rst_wdata", ram_wdata, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        wait_clks(5);

        // Single write
        dbuf[0] = 8'h5A;
        write_txn(7'h10, 1, -1);

        // Burst across the 127->0 wrap
        dbuf[0] = 8'h11; dbuf[1] = 8'h22; dbuf[2] = 8'h33;
        write_txn(7'h7E, 3, -1);
        check("wrap_mem_00", mem[0], 8'h33);

        // Random read with repeated START
        read_txn(7'h10, 1'b1, 1);

        // Address mismatch: bus must stay untouched
        oe0 = oe_cnt; busy0 = busy_cnt; wr0 = wr_cnt; rd0 = rd_cnt;
        i2c_start();
        send_byte(8'hA2, 1'b0, ack);
        check("mis_nack", ack, 1);
        send_byte(8'h55, 1'b0, ack);
        check("mis_nack2", ack, 1);
        i2c_stop();
        wait_clks(4);
        check("mis_oe", oe_cnt - oe0, 0);
        check("mis_busy", busy_cnt - busy0, 0);
        check("mis_wr", wr_cnt - wr0, 0);
        check("mis_rd", rd_cnt - rd0, 0);

        // STOP after 4 data bits
        wr0 = wr_cnt;
        i2c_start();
        send_byte(8'hA0, 1'b0, ack);
        send_byte(8'h20, 1'b0, ack);
        check("part_word_ack", ack, 0);
        bit_cycle(1'b1, s); bit_cycle(1'b0, s); bit_cycle(1'b1, s); bit_cycle(1'b1, s);
        i2c_stop();
        wait_clks(4);
        check("part_no_write", wr_cnt - wr0, 0);
        check("part_busy", busy, 0);
        dbuf[0] = 8'($urandom);
        write_txn(7'h21, 1, -1);

        // Reset during RD_DATA
        dbuf[0] = 8'h00;
        write_txn(7'h30, 1, -1);
        i2c_start();
        send_byte(8'hA0, 1'b0, ack);
        send_byte(8'h30, 1'b0, ack);
        i2c_start();
        send_byte(8'hA1, 1'b0, ack);
        bit_cycle(1'b1, s); bit_cycle(1'b1, s); bit_cycle(1'b1, s);
        check("rdata_driving", sda_oe, 1);
        rst = 1'b1;
        wait_clks(1);
        check("mrst_sda_oe", sda_oe, 0);
        check("mrst_wr_en", ram_wr_en, 0);
        check("mrst_rd_en", ram_rd_en, 0);
        check("mrst_addr", ram_addr, 0);
        check("mrst_wdata", ram_wdata, 0);
        check("mrst_busy", busy, 0);
        scl_m = 1'b1; sda_m = 1'b1;
        wait_clks(4);
        rst = 1'b0;
        ref_ptr = 0;
        wait_clks(4);
        dbuf[0] = 8'hC3;
`ifdef I2C_GLITCH_FILTER_EN
        write_txn(7'h05, 1, 0);
`else
        write_txn(7'h05, 1, -1);
`endif
        read_txn(7'h05, 1'b1, 1);

        // Randomized bursts, read back, then a current-address read
        for (int k = 0; k < 4; k++) begin
            w = 7'($urandom_range(0, 127));
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) dbuf[i] = 8'($urandom);
            write_txn(w, n, -1);
            read_txn(w, 1'b1, n);
            read_txn(7'h00, 1'b0, 1);
        end

        check("no_overlap", overlap_cnt, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
